// File: rtl/xgmii_dec_rx.sv
// 64b/66b receive block decoder with a registered XGMII/XLGMII output stage.
// Each 66-bit block decodes independently into lanes, control bits, flags and a data-byte mask.
module xgmii_dec_rx #(
    parameter bit IS_40G       = 1'b1,
    parameter int DATA_W       = 64,
    parameter int HEAD_W       = 2,
    localparam int LANE0_CNT_N = IS_40G ? 1 : 2
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic [HEAD_W-1:0]      head_i,
    input  logic [DATA_W-1:0]      data_i,
    output logic [DATA_W-1:0]      xgmii_txd_o,
    output logic [DATA_W/8-1:0]    xgmii_txc_o,
    output logic                   ctrl_v_o,
    output logic                   idle_v_o,
    output logic [LANE0_CNT_N-1:0] start_v_o,
    output logic                   term_v_o,
    output logic                   err_v_o,
    output logic                   ord_v_o,
    output logic [DATA_W/8-1:0]    keep_o
);

    localparam logic [7:0] C_IDLE  = 8'h07;
    localparam logic [7:0] C_START = 8'hFB;
    localparam logic [7:0] C_TERM  = 8'hFD;
    localparam logic [7:0] C_ERR   = 8'hFE;
    localparam logic [7:0] C_SEQ   = 8'h9C;

    logic [DATA_W-1:0]      txd_d, txd_q;
    logic [DATA_W/8-1:0]    txc_d, txc_q;
    logic [DATA_W/8-1:0]    keep_d, keep_q;
    logic [LANE0_CNT_N-1:0] start_d, start_q;
    logic                   ctrl_d, ctrl_q, idle_d, idle_q;
    logic                   term_d, term_q, err_d, err_q, ord_d, ord_q;
    logic [DATA_W-1:0]      dataHi;
    logic [7:0]             blockType;
    int                     termK;

    // Defaults describe the unknown-type / invalid-header block; known types override them.
    always_comb begin
        txd_d     = {8{C_ERR}};
        txc_d     = '1;
        keep_d    = '0;
        start_d   = '0;
        ctrl_d    = 1'b1;
        idle_d    = 1'b0;
        term_d    = 1'b0;
        err_d     = 1'b1;
        ord_d     = 1'b0;
        termK     = -1;
        dataHi    = data_i >> 8;
        blockType = data_i[7:0];

        case (blockType)
            8'h87:   termK = 0;
            8'h99:   termK = 1;
            8'hAA:   termK = 2;
            8'hB4:   termK = 3;
            8'hCC:   termK = 4;
            8'hD2:   termK = 5;
            8'hE1:   termK = 6;
            8'hFF:   termK = 7;
            default: termK = -1;
        endcase

        if (head_i == 2'b01) begin
            txd_d  = data_i;
            txc_d  = '0;
            keep_d = '1;
            ctrl_d = 1'b0;
            err_d  = 1'b0;
        end else if (head_i == 2'b10) begin
            if (blockType == 8'h00 || (blockType == 8'h1E && data_i[63:8] == 56'd0)) begin
                txd_d  = {8{C_IDLE}};
                idle_d = 1'b1;
                err_d  = 1'b0;
            end else if (blockType == 8'h1E) begin
                txd_d = {data_i[63:8], C_ERR};
                txc_d = 8'h01;
            end else if (blockType == 8'h78) begin
                txd_d   = {data_i[63:8], C_START};
                txc_d   = 8'h01;
                keep_d  = 8'hFE;
                start_d = 1'b1;
                err_d   = 1'b0;
            end else if (blockType == 8'h4B) begin
                txd_d  = {{4{C_IDLE}}, data_i[31:8], C_SEQ};
                txc_d  = 8'hF1;
                keep_d = 8'h0E;
                ord_d  = 1'b1;
                err_d  = 1'b0;
            end else if (termK >= 0) begin
                // Data bytes shift down one lane because byte 0 held the block type.
                for (int j = 0; j < 8; j++) begin
                    if (j < termK) begin
                        txd_d[8*j +: 8] = dataHi[8*j +: 8];
                        txc_d[j]        = 1'b0;
                        keep_d[j]       = 1'b1;
                    end else if (j == termK) begin
                        txd_d[8*j +: 8] = C_TERM;
                    end else begin
                        txd_d[8*j +: 8] = C_IDLE;
                    end
                end
                term_d = 1'b1;
                err_d  = 1'b0;
            end else if (!IS_40G) begin
                case (blockType)
                    8'h33: begin
                        txd_d                 = {data_i[63:40], C_START, {4{C_IDLE}}};
                        txc_d                 = 8'h1F;
                        keep_d                = 8'hE0;
                        start_d[LANE0_CNT_N-1] = 1'b1;
                        err_d                 = 1'b0;
                    end
                    8'h66: begin
                        txd_d                 = {data_i[63:40], C_START, data_i[31:8], C_SEQ};
                        txc_d                 = 8'h11;
                        keep_d                = 8'hEE;
                        start_d[LANE0_CNT_N-1] = 1'b1;
                        ord_d                 = 1'b1;
                        err_d                 = 1'b0;
                    end
                    8'h2D: begin
                        txd_d  = {data_i[63:40], C_SEQ, {4{C_IDLE}}};
                        txc_d  = 8'h1F;
                        keep_d = 8'hE0;
                        ord_d  = 1'b1;
                        err_d  = 1'b0;
                    end
                    8'h55: begin
                        txd_d  = {data_i[63:40], C_SEQ, data_i[31:8], C_SEQ};
                        txc_d  = 8'h11;
                        keep_d = 8'hEE;
                        ord_d  = 1'b1;
                        err_d  = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            txd_q   <= {8{C_IDLE}};
            txc_q   <= '1;
            keep_q  <= '0;
            start_q <= '0;
            ctrl_q  <= 1'b1;
            idle_q  <= 1'b1;
            term_q  <= 1'b0;
            err_q   <= 1'b0;
            ord_q   <= 1'b0;
        end else begin
            txd_q   <= txd_d;
            txc_q   <= txc_d;
            keep_q  <= keep_d;
            start_q <= start_d;
            ctrl_q  <= ctrl_d;
            idle_q  <= idle_d;
            term_q  <= term_d;
            err_q   <= err_d;
            ord_q   <= ord_d;
        end
    end

    assign xgmii_txd_o = txd_q;
    assign xgmii_txc_o = txc_q;
    assign keep_o      = keep_q;
    assign start_v_o   = start_q;
    assign ctrl_v_o    = ctrl_q;
    assign idle_v_o    = idle_q;
    assign term_v_o    = term_q;
    assign err_v_o     = err_q;
    assign ord_v_o     = ord_q;

endmodule

// File: tb/tb_xgmii_dec_rx.sv
// Self-checking bench for xgmii_dec_rx (40G build): directed cases plus random blocks
// compared against a lane-array reference model.
module tb_xgmii_dec_rx;

    logic        clk;
    logic        nreset;
    logic [1:0]  headI;
    logic [63:0] dataI;
    logic [63:0] txdO;
    logic [7:0]  txcO;
    logic        ctrlV, idleV, termV, errV, ordV;
    logic [0:0]  startV;
    logic [7:0]  keepO;

    int checkCount = 0;
    int failCount  = 0;

    xgmii_dec_rx dut (
        .clk         (clk),
        .nreset      (nreset),
        .head_i      (headI),
        .data_i      (dataI),
        .xgmii_txd_o (txdO),
        .xgmii_txc_o (txcO),
        .ctrl_v_o    (ctrlV),
        .idle_v_o    (idleV),
        .start_v_o   (startV),
        .term_v_o    (termV),
        .err_v_o     (errV),
        .ord_v_o     (ordV),
        .keep_o      (keepO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model: builds the eight lanes as a byte array from the block-type rules.
    function automatic void refModel(input bit rstN, input logic [1:0] h, input logic [63:0] d,
                                     output logic [63:0] eTxd, output logic [7:0] eTxc,
                                     output logic [5:0] eFlags, output logic [7:0] eKeep);
        byte unsigned lane[8];
        bit           ctl[8];
        bit           kp[8];
        byte unsigned termTab[8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
        bit fCtrl = 1, fIdle = 0, fStart = 0, fTerm = 0, fErr = 1, fOrd = 0;
        byte unsigned t = d[7:0];
        int k = -1;
        for (int j = 0; j < 8; j++) begin lane[j] = 8'hFE; ctl[j] = 1; kp[j] = 0; end
        for (int i = 0; i < 8; i++) if (termTab[i] == t) k = i;
        if (!rstN) begin
            for (int j = 0; j < 8; j++) lane[j] = 8'h07;
            fIdle = 1; fErr = 0;
        end else if (h == 2'b01) begin
            for (int j = 0; j < 8; j++) begin lane[j] = d[8*j +: 8]; ctl[j] = 0; kp[j] = 1; end
            fCtrl = 0; fErr = 0;
        end else if (h == 2'b10) begin
            if (t == 8'h00 || (t == 8'h1E && d[63:8] == 0)) begin
                for (int j = 0; j < 8; j++) lane[j] = 8'h07;
                fIdle = 1; fErr = 0;
            end else if (t == 8'h1E) begin
                for (int j = 1; j < 8; j++) begin lane[j] = d[8*j +: 8]; ctl[j] = 0; end
            end else if (t == 8'h78) begin
                lane[0] = 8'hFB;
                for (int j = 1; j < 8; j++) begin lane[j] = d[8*j +: 8]; ctl[j] = 0; kp[j] = 1; end
                fStart = 1; fErr = 0;
            end else if (t == 8'h4B) begin
                lane[0] = 8'h9C;
                for (int j = 1; j < 4; j++) begin lane[j] = d[8*j +: 8]; ctl[j] = 0; kp[j] = 1; end
                for (int j = 4; j < 8; j++) lane[j] = 8'h07;
                fOrd = 1; fErr = 0;
            end else if (k >= 0) begin
                for (int j = 0; j < 8; j++) begin
                    if (j < k) begin lane[j] = d[8*(j+1) +: 8]; ctl[j] = 0; kp[j] = 1; end
                    else if (j == k) lane[j] = 8'hFD;
                    else lane[j] = 8'h07;
                end
                fTerm = 1; fErr = 0;
            end
        end
        for (int j = 0; j < 8; j++) begin
            eTxd[8*j +: 8] = lane[j];
            eTxc[j]        = ctl[j];
            eKeep[j]       = kp[j];
        end
        eFlags = {fCtrl, fIdle, fStart, fTerm, fErr, fOrd};
    endfunction

    task automatic applyStimulus(input string tag, input bit rstN, input logic [1:0] h, input logic [63:0] d);
        logic [63:0] eTxd;
        logic [7:0]  eTxc, eKeep;
        logic [5:0]  eFlags;
        @(negedge clk);
        nreset = rstN;
        headI  = h;
        dataI  = d;
        @(posedge clk);
        #1;
        refModel(rstN, h, d, eTxd, eTxc, eFlags, eKeep);
        checkOutput({tag, ".txd"}, txdO, eTxd);
        checkOutput({tag, ".txc"}, {56'd0, txcO}, {56'd0, eTxc});
        checkOutput({tag, ".flags"}, {58'd0, ctrlV, idleV, startV[0], termV, errV, ordV}, {58'd0, eFlags});
        checkOutput({tag, ".keep"}, {56'd0, keepO}, {56'd0, eKeep});
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [63:0] d;
        byte unsigned termTab[8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
        byte unsigned typeTab[16] = '{8'h00, 8'h1E, 8'h78, 8'h4B, 8'h87, 8'h99, 8'hAA, 8'hB4,
                                      8'hCC, 8'hD2, 8'hE1, 8'hFF, 8'h33, 8'h66, 8'h2D, 8'h55};
        nreset = 1'b0;
        headI  = 2'b10;
        dataI  = '0;

        for (int i = 0; i < 3; i++) applyStimulus("reset", 1'b0, 2'($urandom), rand64());
        for (int i = 0; i < 4; i++) applyStimulus("idle00", 1'b1, 2'b10, {rand64() >> 8, 8'h00});
        applyStimulus("idle1e", 1'b1, 2'b10, 64'h00000000_0000001E);
        applyStimulus("start_fixed", 1'b1, 2'b10, {56'h07060504030201, 8'h78});
        for (int i = 0; i < 3; i++) applyStimulus("start_rand", 1'b1, 2'b10, {rand64() >> 8, 8'h78});
        for (int i = 0; i < 4; i++) begin
            d = {rand64() >> 8, 8'h1E};
            if (d[63:8] == 0) d[20] = 1'b1;
            applyStimulus("error", 1'b1, 2'b10, d);
        end
        applyStimulus("error_msb", 1'b1, 2'b10, 64'h80000000_0000001E);
        for (int k = 0; k < 8; k++) applyStimulus($sformatf("term%0d", k), 1'b1, 2'b10, {rand64() >> 8, termTab[k]});
        for (int i = 0; i < 4; i++) applyStimulus("ordset", 1'b1, 2'b10, {rand64() >> 8, 8'h4B});
        for (int i = 0; i < 8; i++) applyStimulus("data", 1'b1, 2'b01, rand64());
        for (int i = 12; i < 16; i++) applyStimulus("type10g_in40g", 1'b1, 2'b10, {rand64() >> 8, typeTab[i]});
        applyStimulus("unknown_type", 1'b1, 2'b10, {rand64() >> 8, 8'h12});

        applyStimulus("reset_mid", 1'b0, 2'b01, rand64());
        applyStimulus("hdr11", 1'b1, 2'b11, rand64());
        applyStimulus("hdr00", 1'b1, 2'b00, rand64());

        for (int i = 0; i < 300; i++) begin
            logic [1:0] h;
            int sel;
            h   = ($urandom_range(0, 9) == 0) ? 2'($urandom) : (($urandom_range(0, 2) == 0) ? 2'b01 : 2'b10);
            sel = $urandom_range(0, 16);
            d   = rand64();
            if (sel < 16) d[7:0] = typeTab[sel];
            if (sel == 1 && $urandom_range(0, 1) == 0) d[63:8] = '0;
            applyStimulus("random", ($urandom_range(0, 31) != 0), h, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
